// File: rtl/rr_grant_index_arb_pkg.sv
// Round-robin grant-index arbiter: shared constants and state type.
// Sized so the index drives a 5-to-32 decoder directly.
package rr_grant_index_arb_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: lowest set request at or after ptr.
// Double-width copy of req shifted by ptr turns the wrap into a plain scan.
import rr_grant_index_arb_pkg::*;

module rr_pick #(
  parameter int N = rr_grant_index_arb_pkg::N_REQ,
  parameter int W = rr_grant_index_arb_pkg::IDX_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] win_idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;

  // rotate so ptr sits at bit 0, then find the lowest set bit
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    any     = |req;
    win_idx = ptr + off;
  end

endmodule

// File: rtl/rr_grant_index_arb.sv
// Round-robin arbiter emitting a registered grant index plus enable.
// Grants are held until ack or hold timeout, then priority rotates.
import rr_grant_index_arb_pkg::*;

module rr_grant_index_arb #(
  parameter int N_REQ    = rr_grant_index_arb_pkg::N_REQ,
  parameter int IDX_W    = rr_grant_index_arb_pkg::IDX_W,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             timeout
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  localparam bit HOLD_ON = (MAX_HOLD != 0);

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr;
  logic [HW-1:0]    hold_cnt;
  logic             any;
  logic [IDX_W-1:0] win_idx;
  logic             rel_ack;
  logic             rel_to;
  logic             start;

  rr_pick #(
    .N(N_REQ),
    .W(IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .win_idx(win_idx)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state plus release/start qualifiers; ack beats timeout
  always_comb begin
    state_n = state;
    rel_ack = 1'b0;
    rel_to  = 1'b0;
    start   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        start = any;
        if (any) state_n = GRANT;
      end
      (state == GRANT): begin
        rel_ack = ack;
        rel_to  = !ack && HOLD_ON &&
                  (hold_cnt == HOLD_LAST);
        if (rel_ack || rel_to) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // registered outputs, rotation pointer and hold timer
  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      idx      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      en      <= (state_n == GRANT);
      timeout <= rel_to;
      if (start) begin
        idx      <= win_idx;
        hold_cnt <= '0;
      end else if (rel_ack || rel_to) begin
        ptr <= idx + 1'b1;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
